// File: rtl/hazard_unit.sv
// Decode-stage hazard controller: load-use stalls, branch flushes, memory freeze,
// saturating hazard counters and a sticky data-memory timeout flag.
module hazard_unit #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             Branch_taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             DMem_ready,
  input  logic             clr_cnt,
  output logic             Stall,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             Freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StWait = 2'd1,
    StErr  = 2'd2
  } state_e;

  localparam logic [7:0]       WaitLast = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  state_e     state;
  logic [7:0] wait_cnt;

  logic mw;
  logic lu;
  logic br;

  assign mw = EX_MEM_MemAccess & ~DMem_ready;
  assign lu = ID_EX_MemRead & (ID_EX_Rd != 5'd0) &
              ((ID_EX_Rd == IF_ID_Rs1) | (ID_EX_Rd == IF_ID_Rs2));
  assign br = Branch_taken;

  // Priority: reset > mw > br > lu. A deferred branch/load-use reappears once mw clears
  // because the frozen stages keep presenting the same inputs.
  always_comb begin
    Stall        = 1'b0;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    Freeze       = 1'b0;
    if (reset) begin
      Stall       = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (mw) begin
      Freeze      = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (br) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      EX_MEM_Flush = 1'b1;
    end else if (lu) begin
      Stall       = 1'b1;
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end
  end

  // Timeout FSM; mem_timeout is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StRun;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        StRun: begin
          if (mw) begin
            state    <= StWait;
            wait_cnt <= 8'd1;
          end else begin
            wait_cnt <= 8'd0;
          end
        end
        StWait: begin
          if (!mw) begin
            state    <= StRun;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == WaitLast) begin
            state       <= StErr;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        StErr: begin
          if (!mw) begin
            state    <= StRun;
            wait_cnt <= 8'd0;
          end
        end
        default: begin
          state    <= StRun;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Saturating counters; clr_cnt wins over a coincident increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (Stall && (stall_cnt != CntMax)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (IF_ID_Flush && (flush_cnt != CntMax)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (Freeze && (freeze_cnt != CntMax)) begin
        freeze_cnt <= freeze_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (CNT_W=4, TIMEOUT=16) with immediate-assertion checks.
module tb_hazard_unit;

  localparam int unsigned CntW = 4;

  logic            clk;
  logic            reset;
  logic [4:0]      IF_ID_Rs1;
  logic [4:0]      IF_ID_Rs2;
  logic            ID_EX_MemRead;
  logic [4:0]      ID_EX_Rd;
  logic            Branch_taken;
  logic            EX_MEM_MemAccess;
  logic            DMem_ready;
  logic            clr_cnt;
  logic            Stall;
  logic            PCWrite;
  logic            IF_ID_Write;
  logic            IF_ID_Flush;
  logic            ID_EX_Flush;
  logic            EX_MEM_Flush;
  logic            Freeze;
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;
  logic [CntW-1:0] freeze_cnt;
  logic            mem_timeout;

  int passed = 0;
  int total  = 0;

  // {Stall, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Freeze}
  localparam logic [6:0] CtlRst   = 7'b1000000;
  localparam logic [6:0] CtlNone  = 7'b0110000;
  localparam logic [6:0] CtlStall = 7'b1000000;
  localparam logic [6:0] CtlFlush = 7'b0111110;
  localparam logic [6:0] CtlFrz   = 7'b0000001;

  logic [6:0] ctl;
  assign ctl = {Stall, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, Freeze};

  hazard_unit #(
    .CNT_W  (CntW),
    .TIMEOUT(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .IF_ID_Rs1       (IF_ID_Rs1),
    .IF_ID_Rs2       (IF_ID_Rs2),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_Rd        (ID_EX_Rd),
    .Branch_taken    (Branch_taken),
    .EX_MEM_MemAccess(EX_MEM_MemAccess),
    .DMem_ready      (DMem_ready),
    .clr_cnt         (clr_cnt),
    .Stall           (Stall),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Flush     (ID_EX_Flush),
    .EX_MEM_Flush    (EX_MEM_Flush),
    .Freeze          (Freeze),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .freeze_cnt      (freeze_cnt),
    .mem_timeout     (mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    IF_ID_Rs1        = 5'd1;
    IF_ID_Rs2        = 5'd2;
    ID_EX_MemRead    = 1'b0;
    ID_EX_Rd         = 5'd0;
    Branch_taken     = 1'b0;
    EX_MEM_MemAccess = 1'b0;
    DMem_ready       = 1'b1;
    clr_cnt          = 1'b0;
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mw(input logic on);
    EX_MEM_MemAccess = on;
    DMem_ready       = ~on;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    chk("reset_ctl", 32'(ctl), 32'(CtlRst));
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    set_mw(1'b1);
    Branch_taken = 1'b1;
    #1;
    chk("reset_forces_ctl", 32'(ctl), 32'(CtlRst));
    idle();
    cyc();
    reset = 1'b0;
    #1;
    chk("no_hazard_ctl", 32'(ctl), 32'(CtlNone));

    // Load-use on rs2
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5; IF_ID_Rs1 = 5'd3; IF_ID_Rs2 = 5'd5;
    #1;
    chk("lu_rs2_ctl", 32'(ctl), 32'(CtlStall));
    cyc();
    chk("lu_stall_cnt_1", 32'(stall_cnt), 32'd1);
    ID_EX_Rd = 5'd0; IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0;
    #1;
    chk("lu_rd0_no_stall", 32'(ctl), 32'(CtlNone));
    cyc();
    chk("lu_rd0_cnt_hold", 32'(stall_cnt), 32'd1);
    ID_EX_Rd = 5'd7; IF_ID_Rs1 = 5'd7; IF_ID_Rs2 = 5'd9;
    #1;
    chk("lu_rs1_ctl", 32'(ctl), 32'(CtlStall));
    ID_EX_MemRead = 1'b0;
    #1;
    chk("no_load_no_stall", 32'(ctl), 32'(CtlNone));

    // Branch over load-use
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5; IF_ID_Rs2 = 5'd5; Branch_taken = 1'b1;
    #1;
    chk("br_over_lu_ctl", 32'(ctl), 32'(CtlFlush));
    cyc();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

    // Freeze with deferred branch, plus a coincident load-use that must also wait
    idle();
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    Branch_taken = 1'b1;
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd4; IF_ID_Rs1 = 5'd4;
    set_mw(1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("freeze_ctl_%0d", i), 32'(ctl), 32'(CtlFrz));
      cyc();
    end
    DMem_ready = 1'b1;
    #1;
    chk("freeze_release_flush", 32'(ctl), 32'(CtlFlush));
    cyc();
    chk("freeze_cnt_3", 32'(freeze_cnt), 32'd3);
    chk("freeze_flush_cnt_1", 32'(flush_cnt), 32'd1);
    chk("freeze_stall_cnt_0", 32'(stall_cnt), 32'd0);
    Branch_taken = 1'b0;
    #1;
    chk("deferred_lu_ctl", 32'(ctl), 32'(CtlStall));

    // Stall counter saturation, then clear during a stall cycle
    for (int i = 0; i < 20; i++) cyc();
    chk("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr_beats_inc", 32'(stall_cnt), 32'd0);

    // Timeout: 15 mw cycles stay below threshold
    idle();
    set_mw(1'b1);
    for (int i = 0; i < 15; i++) cyc();
    chk("timeout_15_low", 32'(mem_timeout), 32'd0);
    chk("freeze_cnt_sat", 32'(freeze_cnt), 32'd15);
    set_mw(1'b0);
    cyc();
    chk("timeout_after_15_ready", 32'(mem_timeout), 32'd0);

    // Timeout: 16 mw cycles set the flag at the 16th edge
    set_mw(1'b1);
    for (int i = 0; i < 15; i++) cyc();
    chk("timeout_16_pre", 32'(mem_timeout), 32'd0);
    cyc();
    chk("timeout_16_set", 32'(mem_timeout), 32'd1);
    #1;
    chk("err_still_freezes", 32'(ctl), 32'(CtlFrz));
    set_mw(1'b0);
    cyc();
    chk("timeout_sticky_ready", 32'(mem_timeout), 32'd1);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("timeout_sticky_clr", 32'(mem_timeout), 32'd1);
    chk("clr_freeze_cnt", 32'(freeze_cnt), 32'd0);

    // Asynchronous reset away from any clock edge clears the sticky flag
    reset = 1'b1;
    #2;
    chk("async_rst_timeout", 32'(mem_timeout), 32'd0);
    chk("async_rst_ctl", 32'(ctl), 32'(CtlRst));
    reset = 1'b0;

    // Asynchronous reset during WAIT clears counters immediately
    set_mw(1'b1);
    for (int i = 0; i < 5; i++) cyc();
    chk("wait_freeze_cnt_5", 32'(freeze_cnt), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_wait_cnt", 32'(freeze_cnt), 32'd0);
    chk("async_rst_wait_ctl", 32'(ctl), 32'(CtlRst));
    cyc();
    reset = 1'b0;
    #1;
    chk("post_rst_mw_freeze", 32'(ctl), 32'(CtlFrz));

    // A one-cycle gap restarts the consecutive count
    for (int i = 0; i < 10; i++) cyc();
    set_mw(1'b0);
    cyc();
    set_mw(1'b1);
    for (int i = 0; i < 15; i++) cyc();
    chk("gap_restart_low", 32'(mem_timeout), 32'd0);
    cyc();
    chk("gap_restart_set", 32'(mem_timeout), 32'd1);

    idle();
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
